// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block geometry and serializer state types
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_NUM_BYTES = 16;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_IDX_W     = $clog2(AES_NUM_BYTES);

  // IDLE: nothing held; SEND: a block is held and its bytes are being offered
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef logic [AES_IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/cipher_byte_serializer.sv
// rtl/cipher_byte_serializer.sv - 128-bit cipher block to byte stream, B0 first
module cipher_byte_serializer
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = AES_NUM_BYTES,
  parameter int BYTE_W    = AES_BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_BYTES*BYTE_W-1:0] in_cipher,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BYTE_W-1:0]           out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy
);

  localparam int BLOCK_W = NUM_BYTES * BYTE_W;
  localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  ser_state_t         state_q;
  ser_state_t         state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] hold_q;
  logic [BYTE_W-1:0]  sel_byte;
  logic               at_last;
  logic               capture;
  logic               advance;

  // index sits on the final byte; only meaningful while a block is held
  assign at_last = (idx_q == LAST_IDX);

  // a new block is taken whenever the handshake completes, including on the last-byte transfer
  assign capture = in_valid && in_ready;

  // step to the next byte only on a non-final transfer; the index never wraps on its own
  assign advance = (state_q == SEND) && out_ready && !at_last;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // holding register and byte index; in_cipher is sampled only on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      idx_q  <= '0;
    end else if (capture) begin
      hold_q <= in_cipher;
      idx_q  <= '0;
    end else if (advance) begin
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  // next state: stay in SEND across blocks when a new one arrives on the final byte
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SEND;
      SEND:    if (out_ready && at_last && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // byte select from the holding register only, MSB byte first
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_byte = hold_q[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W];
      end
    end
  end

  // outputs: valid/last/byte follow the held block; in_ready opens on IDLE or the final transfer
  always_comb begin
    busy      = (state_q == SEND);
    out_valid = busy;
    out_last  = busy && at_last;
    out_byte  = busy ? sel_byte : '0;
    in_ready  = (state_q == IDLE) || (busy && at_last && out_ready);
  end

endmodule

// File: tb/tb_cipher_byte_serializer.sv
// tb/tb_cipher_byte_serializer.sv - scoreboard bench for cipher_byte_serializer
module tb_cipher_byte_serializer;

  localparam logic [127:0] V1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_cipher;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  logic [8:0]   exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           nbytes  = 0;
  int           nacc    = 0;
  bit           acc     = 1'b0;
  bit           stalled = 1'b0;
  logic [7:0]   stall_byte = '0;
  logic         stall_last = 1'b0;

  cipher_byte_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_cipher (in_cipher),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: sample at negedge, update scoreboard, return at posedge+1
  task automatic step();
    logic [8:0] e;
    acc = 1'b0;
    @(negedge clk);
    if (!rst) begin
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_byte", 32'(out_byte), 32'(stall_byte));
        chk("hold_last", 32'(out_last), 32'(stall_last));
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        nacc++;
        for (int i = 0; i < 16; i++) begin
          exp_q.push_back({(i == 15), in_cipher[(15-i)*8 +: 8]});
        end
      end
      if (out_valid && out_ready) begin
        nbytes++;
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'(out_byte), 32'(e[7:0]));
          chk("last", 32'(out_last), 32'(e[8]));
        end
      end
      stalled    = out_valid && !out_ready;
      stall_byte = out_byte;
      stall_last = out_last;
    end else begin
      stalled = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles, input bit no_gap);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      if (no_gap) chk("no_gap", 32'(out_valid), 32'd1);
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_byte"},  32'(out_byte),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with in_valid and out_ready high: nothing captured
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_cipher = V1;
    repeat (2) begin @(posedge clk); #1; end
    chk_reset_outputs("reset");
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("post_reset_idle", 32'(out_valid), 32'd0);

    // FIPS-197 C.1 block, sink never stalls
    in_cipher = V1; in_valid = 1'b1;
    step();
    chk("c1_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    chk("c1_latency_valid", 32'(out_valid), 32'd1);
    chk("c1_latency_b0", 32'(out_byte), 32'h69);
    drain(40, 1'b1);
    chk("c1_idle_valid", 32'(out_valid), 32'd0);
    chk("c1_idle_ready", 32'(in_ready), 32'd1);

    // back-pressure for 3 cycles at byte index 5
    nbytes = 0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      out_ready = !(c >= 5 && c < 8);
      if (c >= 5 && c < 8) chk("bp_byte", 32'(out_byte), 32'h7b);
      step();
    end
    out_ready = 1'b1;
    drain(20, 1'b1);
    chk("bp_count", 32'(nbytes), 32'd16);

    // back-to-back blocks with in_valid held; in_cipher changes mid-block
    nbytes = 0; nacc = 0;
    in_cipher = V1; in_valid = 1'b1;
    step();
    in_cipher = V2;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      chk("b2b_no_gap", 32'(out_valid), 32'd1);
      chk("b2b_in_ready", 32'(in_ready), 32'(out_last));
      step();
      if (nacc >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(nbytes), 32'd32);
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // in_valid with garbage data mid-block is ignored
    in_cipher = V2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      if (c >= 3 && c < 7) begin
        in_valid  = 1'b1;
        in_cipher = {$urandom, $urandom, $urandom, $urandom};
        chk("mid_in_ready", 32'(in_ready), 32'd0);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;

    // reset after byte 7, then a fresh block starts at B0
    in_cipher = V2; in_valid = 1'b1;
    step();
    in_valid = 1'b0; nbytes = 0;
    for (int c = 0; c < 30 && nbytes < 8; c++) step();
    chk("mid_rst_sent", 32'(nbytes), 32'd8);
    rst = 1'b1; in_valid = 1'b1; in_cipher = V1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    in_cipher = V1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("restart_b0", 32'(out_byte), 32'h69);
    drain(40, 1'b1);
    chk("restart_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_byte_serializer.md
Name: cipher_byte_serializer

Overview:
Downstream stage of the 128-bit cipher merge: accepts one 128-bit ciphertext block per valid/ready handshake and streams it out as 16 bytes on an 8-bit valid/ready interface. Byte order follows FIPS-197: B0 (bits 127:120) first, B15 (bits 7:0) last. A single holding register allows back-to-back blocks with no bubble when the sink never stalls. It sits between the AES core output and the byte-wide transmit path (UART/bus bridge).

Parameters:
NUM_BYTES, 16, bytes per block; block width = NUM_BYTES*BYTE_W
BYTE_W, 8, width of each output symbol

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_cipher  input  NUM_BYTES*BYTE_W  ciphertext block; MSB byte is B0
in_valid  input  1  in_cipher is valid
in_ready  output  1  block accepted when in_valid && in_ready
out_byte  output  BYTE_W  current byte
out_valid  output  1  out_byte is valid
out_ready  input  1  sink accepts out_byte when out_valid && out_ready
out_last  output  1  high with the final byte (B15) of a block
busy  output  1  high while a block is held (state SEND)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, byte index=0, holding register=0, out_valid=0, out_last=0, out_byte=0, busy=0. Reset dominates all other inputs, including mid-block; any partially sent block is discarded.
- States: IDLE (no block held), SEND (block held, bytes being offered).
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). Combinational; independent of in_valid.
- IDLE: if in_valid, capture in_cipher into the holding register, index=0, go to SEND. out_valid is asserted in the cycle after acceptance (latency: 1 clock from accept to B0 presented).
- SEND: out_valid=1, out_byte=holding[(NUM_BYTES-1-index)*BYTE_W +: BYTE_W], out_last=(index==NUM_BYTES-1).
  - out_ready=0: hold out_byte, out_last and index unchanged (AXI-style stability; out_valid never drops once raised until transfer).
  - out_ready=1 and not last: index increments by 1.
  - out_ready=1 and last: if in_valid, capture the new block, index=0, stay in SEND (no bubble); else go to IDLE, out_valid=0 next cycle.
- Index counter is $clog2(NUM_BYTES) bits; it never wraps past NUM_BYTES-1 (reset to 0 only on capture).
- Throughput: NUM_BYTES cycles per block with out_ready held high and in_valid asserted continuously.
- in_cipher is sampled only on the accepting edge; later changes have no effect on the block in flight.
- busy = (state==SEND).
- out_byte is registered/muxed from the holding register only; no combinational path from in_cipher to out_byte.

Decomposition:
- Shared package aes_pkg: AES_BLOCK_W=128, AES_NUM_BYTES=16, AES_BYTE_W=8, state enum {IDLE, SEND}, byte-index type sized $clog2(AES_NUM_BYTES).
- Single module; no sub-module warranted (FSM + index counter + 128-bit register + byte mux).

Test Plan:
- FIPS-197 C.1 vector: in_cipher=128'h69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> bytes 69,c4,e0,d8,...,c5,5a on 16 consecutive cycles starting 1 cycle after accept; out_last only with 5a; then out_valid=0, in_ready=1.
- Back-pressure: same vector, out_ready low for 3 cycles at byte index 5 (8'h7b) -> out_byte stays 7b, out_valid stays 1, index frozen; sequence resumes intact with no lost or duplicated byte.
- Back-to-back: two blocks (C.1 vector, then 128'h000102030405060708090a0b0c0d0e0f) with in_valid held -> 32 consecutive valid bytes, 00 follows 5a in the very next cycle; in_ready pulses exactly on the 5a transfer cycle.
- in_valid during SEND not at last byte -> in_ready=0, block not captured; in_cipher changes mid-block do not alter output.
- Reset mid-operation: assert rst after byte 7 -> next cycle out_valid=0, busy=0, in_ready=1, out_byte=0; a new block then starts from B0.
- Reset with in_valid=1 and out_ready=1 -> no capture on the reset edge; all outputs at reset values.
